// File: rtl/mem_line_responder_pkg.sv
// Shared types for the line-granular memory responder: FSM states, operation
// codes and the latency counter width.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int CNT_W = 8;

endpackage

// File: rtl/mem_line_responder_if.sv
// Cache <-> memory line interface. The cache side is the master, the
// responder is the slave; proto_err travels with the bus for convenience.
interface mem_line_responder_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int LINE_WIDTH = 128
);
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic                  proto_err;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, proto_err
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, proto_err
  );
endinterface

// File: rtl/mem_line_responder_array.sv
// Line storage: one synchronous write port, one synchronous read port with a
// registered output. Contents are deliberately not reset.
module mem_resp_array #(
  parameter int LINE_WIDTH = 128,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [LINE_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [LINE_WIDTH-1:0] rdata_q
);

  logic [LINE_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

endmodule

// File: rtl/mem_line_responder.sv
// Line read/write responder with programmable latency and a one-cycle ready
// pulse. Optional protocol checker enabled by macro MEM_RESP_PROTO_CHECK_EN.
module mem_line_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int LINE_WIDTH = 128,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_line_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  op_e                     op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    rd_valid_q, rd_valid_d;

  logic                    req;
  op_e                     req_op;
  logic                    arr_re;
  logic                    arr_we;
  logic [DEPTH_LOG2-1:0]   arr_raddr;
  logic [LINE_WIDTH-1:0]   arr_rdata;

  assign req    = bus.mem_read | bus.mem_write;
  assign req_op = bus.mem_write ? OP_WR : OP_RD;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_valid_d = rd_valid_q;
    arr_re     = 1'b0;
    arr_raddr  = addr_q[DEPTH_LOG2-1:0];
    case (state_q)
      IDLE: begin
        if (req) begin
          op_d    = req_op;
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          cnt_d   = LAT_M1;
          if (LATENCY == 1) begin
            state_d = RESP;
            // Nothing is latched yet, so the read index comes straight off the bus.
            if (req_op == OP_RD) begin
              arr_re     = 1'b1;
              arr_raddr  = bus.mem_addr[DEPTH_LOG2-1:0];
              rd_valid_d = 1'b1;
            end
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          if (op_q == OP_RD) begin
            arr_re     = 1'b1;
            rd_valid_d = 1'b1;
          end
        end
      end
      RESP:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_RD;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Write commits on the edge leaving RESP, so a reset during the response drops it.
  assign arr_we = (state_q == RESP) && (op_q == OP_WR) && !rst;

  mem_resp_array #(
    .LINE_WIDTH (LINE_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .we      (arr_we),
    .waddr   (addr_q[DEPTH_LOG2-1:0]),
    .wdata   (wdata_q),
    .re      (arr_re && !rst),
    .raddr   (arr_raddr),
    .rdata_q (arr_rdata)
  );

  // The array output flop has no reset; rd_valid_q gives mem_rdata its zero reset value.
  assign bus.mem_rdata = rd_valid_q ? arr_rdata : '0;
  assign bus.mem_ready = (state_q == RESP);

`ifdef MEM_RESP_PROTO_CHECK_EN
  logic proto_err_q, proto_err_d;
  logic req_prev_q;

  always_comb begin
    proto_err_d = proto_err_q;
    if ((state_q == IDLE) && bus.mem_read && bus.mem_write) proto_err_d = 1'b1;
    if (((state_q == BUSY) || (state_q == RESP)) && req &&
        ((bus.mem_addr != addr_q) || (req_op != op_q)))      proto_err_d = 1'b1;
    if ((state_q == HOLD) && req && !req_prev_q)             proto_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_q <= 1'b0;
      req_prev_q  <= 1'b0;
    end else begin
      proto_err_q <= proto_err_d;
      req_prev_q  <= req;
    end
  end

  assign bus.proto_err = proto_err_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[ADDR_WIDTH-1:DEPTH_LOG2];
  assign bus.proto_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: a LATENCY=4 and a LATENCY=1 instance share one
// stimulus stream; a timestamp-based model predicts ready/rdata for both.
module tb_mem_line_responder;

  localparam int LAT4 = 4;
  localparam int LAT1 = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd = 1'b0;
  logic         wr = 1'b0;
  logic [27:0]  addr = '0;
  logic [127:0] wdata = '0;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int pulses4 = 0;

  always #5 clk = ~clk;

  mem_line_responder_if bus4 ();
  mem_line_responder_if bus1 ();

  assign bus4.mem_read  = rd;
  assign bus4.mem_write = wr;
  assign bus4.mem_addr  = addr;
  assign bus4.mem_wdata = wdata;
  assign bus1.mem_read  = rd;
  assign bus1.mem_write = wr;
  assign bus1.mem_addr  = addr;
  assign bus1.mem_wdata = wdata;

  mem_line_responder #(.LATENCY(LAT4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mem_line_responder #(.LATENCY(LAT1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: each instance accepts a request when idle and past its
  // turnaround, pulses ready LAT-1 edges after accept, commits writes one edge later.
  longint       cyc = 0;
  bit           m_busy   [2];
  longint       m_tacc   [2];
  longint       m_nextok [2];
  bit           m_wr     [2];
  logic [7:0]   m_idx    [2];
  logic [127:0] m_wd     [2];
  logic [127:0] m_mem    [2][256];
  bit           m_known  [2][256];
  bit           e_ready  [2];
  logic [127:0] e_rdata  [2];
  bit           e_rknown [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT4 : LAT1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k]   = 1'b0;
        m_nextok[k] = cyc + 1;
        e_ready[k]  = 1'b0;
        e_rdata[k]  = '0;
        e_rknown[k] = 1'b1;
      end else begin
        e_ready[k] = 1'b0;
        if (m_busy[k] && cyc == m_tacc[k] + lat_of(k)) begin
          if (m_wr[k]) begin
            m_mem[k][m_idx[k]]   = m_wd[k];
            m_known[k][m_idx[k]] = 1'b1;
          end
          m_busy[k]   = 1'b0;
          m_nextok[k] = cyc + 2;
        end
        if (!m_busy[k] && cyc >= m_nextok[k] && (rd || wr)) begin
          m_busy[k] = 1'b1;
          m_tacc[k] = cyc;
          m_wr[k]   = wr;
          m_idx[k]  = addr[7:0];
          m_wd[k]   = wdata;
        end
        if (m_busy[k] && cyc == m_tacc[k] + lat_of(k) - 1) begin
          e_ready[k] = 1'b1;
          if (!m_wr[k]) begin
            e_rdata[k]  = m_mem[k][m_idx[k]];
            e_rknown[k] = m_known[k][m_idx[k]];
          end
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (bus4.mem_ready) pulses4++;
      chk("ready4", bus4.mem_ready, e_ready[0]);
      chk("ready1", bus1.mem_ready, e_ready[1]);
      if (e_rknown[0]) chk("rdata4", bus4.mem_rdata, e_rdata[0]);
      if (e_rknown[1]) chk("rdata1", bus1.mem_rdata, e_rdata[1]);
`ifndef MEM_RESP_PROTO_CHECK_EN
      chk("proto4_off", bus4.proto_err, 0);
      chk("proto1_off", bus1.proto_err, 0);
`endif
    end
  end

  // Cache-style transaction: hold request until the LATENCY=4 pulse, keep it one
  // more cycle, then optionally drop it.
  int           t_n4, t_n1;
  logic [127:0] t_r4a, t_r4b, t_r1a, t_r1b;

  task automatic xact(input bit w, input bit r, input logic [27:0] a,
                      input logic [127:0] d, input bit drop);
    rd = r; wr = w; addr = a; wdata = d;
    t_n4 = -1; t_n1 = -1;
    for (int n = 1; n <= 20 && t_n4 < 0; n++) begin
      @(posedge clk); #1;
      if (t_n1 > 0 && n == t_n1 + 1) t_r1b = bus1.mem_rdata;
      if (bus1.mem_ready && t_n1 < 0) begin
        t_n1  = n;
        t_r1a = bus1.mem_rdata;
      end
      if (bus4.mem_ready) begin
        t_n4  = n;
        t_r4a = bus4.mem_rdata;
      end
    end
    @(posedge clk); #1;
    t_r4b = bus4.mem_rdata;
    @(posedge clk); #1;
    if (drop) begin
      rd = 1'b0; wr = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  localparam logic [127:0] DA5 = {16{8'hA5}};
  localparam logic [127:0] D1  = 128'h0123_4567_89AB_CDEF_1122_3344_5566_7788;
  localparam logic [127:0] DX  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] DP  = 128'hCAFE_0003_CAFE_0003_CAFE_0003_CAFE_0003;
  localparam logic [127:0] DQ  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
  localparam logic [127:0] D6  = 128'h6666_0000_6666_0000_6666_0000_6666_0000;

  initial begin
    int c0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_ready4", bus4.mem_ready, 0);
    chk("rst_rdata4", bus4.mem_rdata, 0);
    chk("rst_proto4", bus4.proto_err, 0);
    chk("rst_rdata1", bus1.mem_rdata, 0);

    // Basic write then read at address 5
    xact(1, 0, 28'h0000005, DA5, 1);
    chk("wr5_lat4", t_n4, 4);
    chk("wr5_lat1", t_n1, 1);
    xact(0, 1, 28'h0000005, '0, 1);
    chk("rd5_lat4", t_n4, 4);
    chk("rd5_data4_pulse", t_r4a, DA5);
    chk("rd5_data4_next", t_r4b, DA5);
    chk("rd5_lat1", t_n1, 1);
    chk("rd5_data1_pulse", t_r1a, DA5);
    chk("rd5_data1_next", t_r1b, DA5);

    // Write-back then fetch with request held across the turnaround
    idle(4);
    c0 = pulses4;
    xact(1, 0, 28'h0000010, D1, 0);
    xact(0, 1, 28'h0000010, '0, 1);
    chk("wbf_fetch_lat4", t_n4, 4);
    chk("wbf_fetch_data", t_r4a, D1);
    idle(8);
    chk("wbf_pulses", pulses4 - c0, 2);

    // Index aliasing on the upper address bits
    xact(1, 0, 28'h0000105, DX, 1);
    xact(0, 1, 28'h0000005, '0, 1);
    chk("alias_data", t_r4a, DX);

    // Reset during BUSY of a write drops it
    xact(1, 0, 28'h0000003, DP, 1);
    idle(2);
    rd = 1'b0; wr = 1'b1; addr = 28'h0000003; wdata = DQ;
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0; wr = 1'b0;
    c0 = pulses4;
    idle(6);
    chk("rst_busy_nopulse", pulses4 - c0, 0);
    xact(0, 1, 28'h0000003, '0, 1);
    chk("rst_busy_old_data", t_r4a, DP);

    // Read and write together: write wins
    idle(3);
    xact(1, 1, 28'h0000020, D6, 1);
`ifdef MEM_RESP_PROTO_CHECK_EN
    chk("rw_proto_set", bus4.proto_err, 1);
`else
    chk("rw_proto_off", bus4.proto_err, 0);
`endif
    xact(0, 1, 28'h0000020, '0, 1);
    chk("rw_write_won", t_r4a, D6);
`ifdef MEM_RESP_PROTO_CHECK_EN
    chk("rw_proto_sticky", bus4.proto_err, 1);
`endif
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rw_proto_cleared", bus4.proto_err, 0);

    // Randomized traffic, model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rd    = ($urandom_range(0, 2) == 0);
        wr    = ($urandom_range(0, 2) == 0);
        addr  = {20'($urandom), 8'($urandom_range(0, 15))};
        wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      rst = ($urandom_range(0, 299) == 0);
      idle(1);
    end
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
